bat_key_ctrl: RTL and testbench

//  Upstream of the bat movement stage. Decodes PS/2 set-2 scan-code bytes from the keyboard receiver.

---
 rtl/bat_key_ctrl.sv | 125 ++++++++++++
 tb/tb_bat_key_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bat_key_ctrl.sv
// PS/2 set-2 scan-code decoder for bat control: held right/left levels and launch pulse.
// Optional BAT_KEY_LAST_WINS_EN: when both arrows are held, only the last-made one is driven.
module bat_key_ctrl #(
    parameter logic [7:0] KEY_RIGHT   = 8'h74,
    parameter logic [7:0] KEY_LEFT    = 8'h6B,
    parameter logic [7:0] KEY_LAUNCH  = 8'h29,
    parameter int         PREFIX_TOUT = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_new,
    output logic       right,
    output logic       left,
    output logic       launch
);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    localparam logic [7:0]  BYTE_EXT  = 8'hE0;
    localparam logic [7:0]  BYTE_BRK  = 8'hF0;
    localparam logic [19:0] TOUT_LAST = 20'(PREFIX_TOUT - 1);
    localparam logic [19:0] CNT_MAX   = '1;

    state_t      state;
    logic [19:0] tcnt;
    logic        held_r;
    logic        held_l;
    logic        launch_q;
    logic        tout;
    logic        sel_r;
    logic        sel_l;

    assign tout = (state != IDLE) && (tcnt == TOUT_LAST);

    // A byte arriving on the timeout cycle is decoded; the timeout only acts without one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tcnt     <= '0;
            held_r   <= 1'b0;
            held_l   <= 1'b0;
            launch_q <= 1'b0;
        end else begin
            launch_q <= 1'b0;
            if (din_new) begin
                tcnt <= '0;
                unique case (state)
                    IDLE: begin
                        if (din == BYTE_EXT) begin
                            state <= EXT;
                        end else if (din == BYTE_BRK) begin
                            state <= BRK;
                        end else begin
                            state <= IDLE;
                            if (din == KEY_LAUNCH) launch_q <= 1'b1;
                        end
                    end
                    EXT: begin
                        if (din == BYTE_EXT) begin
                            state <= EXT;
                        end else if (din == BYTE_BRK) begin
                            state <= EXT_BRK;
                        end else begin
                            state <= IDLE;
                            if (din == KEY_RIGHT) held_r <= 1'b1;
                            else if (din == KEY_LEFT) held_l <= 1'b1;
                        end
                    end
                    BRK: begin
                        state <= IDLE;
                    end
                    EXT_BRK: begin
                        if (din == BYTE_EXT) begin
                            state <= EXT;
                        end else begin
                            state <= IDLE;
                            if (din == KEY_RIGHT) held_r <= 1'b0;
                            else if (din == KEY_LEFT) held_l <= 1'b0;
                        end
                    end
                endcase
            end else if (state == IDLE || tout) begin
                state <= IDLE;
                tcnt  <= '0;
            end else if (tcnt != CNT_MAX) begin
                tcnt <= tcnt + 20'd1;
            end
        end
    end

`ifdef BAT_KEY_LAST_WINS_EN
    logic last_r;

    // Remembers which arrow was made most recently (1 = right).
    always_ff @(posedge clk) begin
        if (reset) begin
            last_r <= 1'b0;
        end else if (din_new && state == EXT &&
                     din != BYTE_EXT && din != BYTE_BRK) begin
            if (din == KEY_RIGHT) last_r <= 1'b1;
            else if (din == KEY_LEFT) last_r <= 1'b0;
        end
    end

    assign sel_r = held_r & (~held_l | last_r);
    assign sel_l = held_l & (~held_r | ~last_r);
`else
    assign sel_r = held_r;
    assign sel_l = held_l;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            right  <= 1'b0;
            left   <= 1'b0;
            launch <= 1'b0;
        end else begin
            right  <= sel_r;
            left   <= sel_l;
            launch <= launch_q;
        end
    end

endmodule

// File: tb/tb_bat_key_ctrl.sv
// Scoreboard bench for bat_key_ctrl: directed scan-code sequences, per-cycle expected outputs.
// Expectations follow BAT_KEY_LAST_WINS_EN when the build defines it.
module tb_bat_key_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] din;
    logic       din_new;
    logic       right;
    logic       left;
    logic       launch;

    int cyc;
    int n_cmp;
    int n_bad;

    typedef struct {
        int    c;
        logic  r;
        logic  l;
        logic  la;
        string nm;
    } exp_t;

    exp_t sb[$];

    bat_key_ctrl #(.PREFIX_TOUT(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .din     (din),
        .din_new (din_new),
        .right   (right),
        .left    (left),
        .launch  (launch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares at the falling edge of the cycle each entry names.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].c < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: check at cycle %0d missed (now %0d)",
                     sb[0].nm, sb[0].c, cyc);
            void'(sb.pop_front());
        end
        while (sb.size() > 0 && sb[0].c == cyc) begin
            n_cmp++;
            if ({right, left, launch} !== {sb[0].r, sb[0].l, sb[0].la}) begin
                n_bad++;
                $display("FAIL %s: cycle %0d r/l/launch got %b%b%b expected %b%b%b",
                         sb[0].nm, cyc, right, left, launch,
                         sb[0].r, sb[0].l, sb[0].la);
            end
            void'(sb.pop_front());
        end
    end

    task automatic chk(input int c, input logic r, input logic l,
                       input logic la, input string nm);
        exp_t e;
        e.c  = c;
        e.r  = r;
        e.l  = l;
        e.la = la;
        e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // gap = idle cycles before the strobe; gap 0 gives back-to-back strobes.
    task automatic send(input logic [7:0] b, input int gap);
        din_new = 1'b0;
        idle(gap);
        din     = b;
        din_new = 1'b1;
        @(posedge clk);
        #1;
        din_new = 1'b0;
        din     = 8'h00;
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
    endtask

    int first;

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b1;
        din     = 8'h00;
        din_new = 1'b0;

        // Reset held 3 cycles while E0 strobes arrive.
        repeat (3) begin
            din     = 8'hE0;
            din_new = 1'b1;
            @(posedge clk);
            #1;
        end
        reset   = 1'b0;
        din_new = 1'b0;
        chk(cyc, 0, 0, 0, "reset_out");
        send(8'h74, 1);
        chk(cyc + 1, 0, 0, 0, "reset_drops_e0");

        // Make/break of right arrow with latency check.
        send(8'hE0, 1);
        send(8'h74, 1);
        chk(cyc, 0, 0, 0, "make_latency");
        chk(cyc + 1, 1, 0, 0, "make_right");
        send(8'hE0, 1);
        send(8'hF0, 1);
        send(8'h74, 1);
        chk(cyc, 1, 0, 0, "break_latency");
        chk(cyc + 1, 0, 0, 0, "break_right");

        // Launch pulse, launch break, keypad 6.
        send(8'h29, 1);
        chk(cyc, 0, 0, 0, "launch_pre");
        chk(cyc + 1, 0, 0, 1, "launch_pulse");
        chk(cyc + 2, 0, 0, 0, "launch_one_cycle");
        send(8'hF0, 3);
        send(8'h29, 1);
        chk(cyc + 1, 0, 0, 0, "launch_break_a");
        chk(cyc + 2, 0, 0, 0, "launch_break_b");
        send(8'h74, 3);
        chk(cyc + 1, 0, 0, 0, "keypad6");

        // din without strobe is ignored.
        din = 8'hE0;
        idle(3);
        send(8'h74, 0);
        chk(cyc + 1, 0, 0, 0, "no_strobe_ignored");

        // Prefix timeout and its boundaries (PREFIX_TOUT = 8).
        send(8'hE0, 2);
        send(8'h74, 9);
        chk(cyc + 1, 0, 0, 0, "tout_discard");
        send(8'hE0, 2);
        send(8'h74, 4);
        chk(cyc + 1, 1, 0, 0, "tout_within");
        send(8'hE0, 2);
        send(8'hF0, 7);
        send(8'h74, 7);
        chk(cyc + 1, 0, 0, 0, "tout_edge_byte_wins");
        send(8'hE0, 2);
        send(8'h74, 8);
        chk(cyc + 1, 0, 0, 0, "tout_edge_expired");

        // Both arrows held.
        send(8'hE0, 2);
        send(8'h74, 1);
        send(8'hE0, 1);
        send(8'h6B, 1);
`ifdef BAT_KEY_LAST_WINS_EN
        chk(cyc + 1, 0, 1, 0, "both_held");
`else
        chk(cyc + 1, 1, 1, 0, "both_held");
`endif
        send(8'hE0, 1);
        send(8'hF0, 1);
        send(8'h6B, 1);
        chk(cyc + 1, 1, 0, 0, "release_left");
        send(8'hE0, 1);
        send(8'hF0, 1);
        send(8'h74, 1);
        chk(cyc + 1, 0, 0, 0, "release_right");

        // Spacing: back-to-back strobes and 1000-cycle gaps between sequences.
        send(8'hE0, 1000);
        send(8'h74, 0);
        chk(cyc + 1, 1, 0, 0, "gap0_make");
        send(8'hE0, 1000);
        send(8'hF0, 0);
        send(8'h74, 0);
        chk(cyc + 1, 0, 0, 0, "gap0_break");
        send(8'hE0, 1000);
        send(8'h6B, 1);
        chk(cyc + 1, 0, 1, 0, "gap1_make_left");
        send(8'hE0, 1000);
        send(8'hF0, 1);
        send(8'h6B, 1);
        chk(cyc + 1, 0, 0, 0, "gap1_break_left");

        // Typematic repeat, checked every cycle for glitches.
        send(8'hE0, 2);
        send(8'h74, 0);
        first = cyc;
        repeat (4) begin
            send(8'hE0, 0);
            chk(cyc, 1, 0, 0, "typematic");
            send(8'h74, 0);
            chk(cyc, 1, 0, 0, "typematic");
        end
        chk(cyc + 1, 1, 0, 0, "typematic_end");
        idle(3);

        // Reset clears a held key; reset mid-sequence drops the prefix.
        pulse_reset();
        chk(cyc, 0, 0, 0, "reset_clears_held");
        send(8'hE0, 1);
        pulse_reset();
        send(8'h74, 1);
        chk(cyc + 1, 0, 0, 0, "reset_mid_prefix");

        for (int i = 0; i < 50 && sb.size() > 0; i++) idle(1);
        while (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: check at cycle %0d never reached",
                     sb[0].nm, sb[0].c);
            void'(sb.pop_front());
        end
        if (first == 0) begin
            n_bad++;
            $display("FAIL typematic_start: cycle %0d required nonzero", first);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
